alu_cmd_fifo: RTL and testbench

- Command buffer directly upstream of the 16-bit ALU.
- Accepts {opcode, op1, op2} commands through a valid/ready handshake and stores them in a circular FIFO.
- Presents the oldest command on its output, which drives the ALU operand and opcode inputs.
- Decouples the command producer from the consumer that samples the ALU result.

---
 rtl/alu_cmd_fifo.sv | 128 ++++++++++++
 tb/tb_alu_cmd_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_fifo
// Purpose  : Circular command FIFO placed directly in front of the 16-bit ALU.
//            It accepts {opcode, op1, op2} through a valid/ready handshake and
//            presents the oldest command first-word-fall-through, so the head
//            entry drives the ALU operand and opcode inputs directly.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int ALU_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ALU_WIDTH-1:0]         in_op1,
  input  logic [ALU_WIDTH-1:0]         in_op2,
  input  logic [1:0]                   in_opcode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ALU_WIDTH-1:0]         out_op1,
  output logic [ALU_WIDTH-1:0]         out_op2,
  output logic [1:0]                   out_opcode,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE    = PTR_W'(1);

  // Storage is intentionally not reset; only pointers, count and flags are.
  logic [ALU_WIDTH-1:0] r_op1_mem    [DEPTH];
  logic [ALU_WIDTH-1:0] r_op2_mem    [DEPTH];
  logic [1:0]           r_opcode_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full/empty come from the occupancy counter, never from pointer compares,
  // so wrapped pointers are never ambiguous.
  assign w_full  = (r_count == C_FULL_COUNT);
  assign w_empty = (r_count == '0);

  // in_ready depends on registered state and rst only: a full FIFO never
  // admits a push even when the head is popped in the same cycle.
  assign in_ready  = !w_full && !rst;
  assign out_valid = !w_empty;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Write the incoming command into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op1_mem[r_wr_ptr]    <= in_op1;
      r_op2_mem[r_wr_ptr]    <= in_op2;
      r_opcode_mem[r_wr_ptr] <= in_opcode;
    end
  end

  // Advance the pointers on push/pop; DEPTH is a power of two so they wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
    end
  end

  // Track occupancy; push and pop together leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for any push attempt made while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (in_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  // Present the head entry while valid and zeros otherwise, so the ALU sees
  // a defined, quiet input whenever the FIFO is empty.
  always_comb begin
    out_op1    = '0;
    out_op2    = '0;
    out_opcode = '0;
    if (out_valid) begin
      out_op1    = r_op1_mem[r_rd_ptr];
      out_op2    = r_op2_mem[r_rd_ptr];
      out_opcode = r_opcode_mem[r_rd_ptr];
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_fifo
// Purpose  : Self-checking bench for alu_cmd_fifo. Expected commands are kept
//            in a scoreboard queue and compared against the head as it is
//            consumed; a small ALU model checks the resulting ALU values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_fifo;

  localparam int ALU_WIDTH = 16;
  localparam int DEPTH     = 4;

  typedef struct packed {
    logic [1:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_op1;
  logic [15:0] in_op2;
  logic [1:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_op1;
  logic [15:0] out_op2;
  logic [1:0]  out_opcode;
  logic [2:0]  count;
  logic        overflow;

  int   n_tests = 0;
  int   n_fail  = 0;
  cmd_t sb[$];

  alu_cmd_fifo #(.ALU_WIDTH(ALU_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_opcode(in_opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_opcode(out_opcode),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the downstream ALU driven by the FIFO head.
  function automatic logic [15:0] alu(input logic [1:0] opc, input logic [15:0] a, input logic [15:0] b);
    case (opc)
      2'd0:    alu = a + b;
      2'd1:    alu = a - b;
      2'd2:    alu = a & b;
      default: alu = a | b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input cmd_t c);
    in_valid  = v;
    in_opcode = c.opc;
    in_op1    = c.a;
    in_op2    = c.b;
  endtask

  task automatic test_reset();
    cmd_t z;
    z = '0;
    rst = 1'b1; out_ready = 1'b0; drive(1'b0, z);
    tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready actual=%b required=0", in_ready); end
    n_tests++;
    if ({out_valid, count, overflow, out_opcode, out_op1, out_op2} !== 39'd0) begin
      n_fail++; $display("FAIL reset_state actual v=%b cnt=%0d ovf=%b out=%h/%h/%h required all zero",
                         out_valid, count, overflow, out_opcode, out_op1, out_op2);
    end
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready actual=%b required=1", in_ready); end
  endtask

  task automatic test_single();
    cmd_t c;
    c = '{opc: 2'd0, a: 16'h0005, b: 16'h0003};
    drive(1'b1, c); sb.push_back(c);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({out_valid, count, out_opcode, out_op1, out_op2} !== {1'b1, 3'd1, c}) begin
        n_fail++; $display("FAIL single_head[%0d] actual v=%b cnt=%0d cmd=%h required v=1 cnt=1 cmd=%h",
                           i, out_valid, count, {out_opcode, out_op1, out_op2}, c);
      end
      n_tests++; if (alu(out_opcode, out_op1, out_op2) !== 16'h0008) begin n_fail++; $display("FAIL single_alu[%0d] actual=%h required=0008", i, alu(out_opcode, out_op1, out_op2)); end
      tick();
    end
    out_ready = 1'b1;
    n_tests++; if ({out_opcode, out_op1, out_op2} !== sb[0]) begin n_fail++; $display("FAIL single_pop actual=%h required=%h", {out_opcode, out_op1, out_op2}, sb[0]); end
    void'(sb.pop_front());
    tick();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, count, out_opcode, out_op1, out_op2} !== 38'd0) begin
      n_fail++; $display("FAIL single_empty actual v=%b cnt=%0d cmd=%h required all zero", out_valid, count, {out_opcode, out_op1, out_op2});
    end
  endtask

  task automatic test_fill_overflow();
    cmd_t c;
    logic [15:0] exp_alu [4];
    exp_alu[0] = 16'h00E0; exp_alu[1] = 16'hE100; exp_alu[2] = 16'h00F0; exp_alu[3] = 16'hFFF0;
    for (int i = 0; i < 4; i++) begin
      c = '{opc: 2'(i), a: 16'hF0F0, b: 16'h0FF0};
      drive(1'b1, c); sb.push_back(c);
      tick();
    end
    in_valid = 1'b0;
    n_tests++; if ({count, in_ready, overflow} !== {3'd4, 1'b0, 1'b0}) begin n_fail++; $display("FAIL fill_full actual cnt=%0d rdy=%b ovf=%b required cnt=4 rdy=0 ovf=0", count, in_ready, overflow); end
    c = '{opc: 2'd1, a: 16'hDEAD, b: 16'hBEEF};
    drive(1'b1, c);
    tick();
    in_valid = 1'b0;
    n_tests++; if ({count, overflow} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL fill_overflow actual cnt=%0d ovf=%b required cnt=4 ovf=1", count, overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (!out_valid || {out_opcode, out_op1, out_op2} !== sb[0]) begin n_fail++; $display("FAIL drain_order[%0d] actual v=%b cmd=%h required v=1 cmd=%h", i, out_valid, {out_opcode, out_op1, out_op2}, sb[0]); end
      n_tests++; if (alu(out_opcode, out_op1, out_op2) !== exp_alu[i]) begin n_fail++; $display("FAIL drain_alu[%0d] actual=%h required=%h", i, alu(out_opcode, out_op1, out_op2), exp_alu[i]); end
      void'(sb.pop_front());
      tick();
    end
    out_ready = 1'b0;
    n_tests++; if ({count, out_valid, overflow} !== {3'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL drain_end actual cnt=%0d v=%b ovf=%b required cnt=0 v=0 ovf=1", count, out_valid, overflow); end
  endtask

  task automatic test_back_to_back();
    cmd_t c;
    for (int i = 0; i < 2; i++) begin
      c = '{opc: 2'(i), a: 16'h0100 + 16'(i), b: 16'h0011};
      drive(1'b1, c); sb.push_back(c);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      c = '{opc: 2'(i), a: 16'h0100 + 16'(i), b: 16'h0011};
      drive(1'b1, c);
      n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d] actual=%0d required=2", i, count); end
      n_tests++; if (!out_valid || {out_opcode, out_op1, out_op2} !== sb[0]) begin n_fail++; $display("FAIL b2b_order[%0d] actual v=%b cmd=%h required v=1 cmd=%h", i, out_valid, {out_opcode, out_op1, out_op2}, sb[0]); end
      void'(sb.pop_front()); sb.push_back(c);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (!out_valid || {out_opcode, out_op1, out_op2} !== sb[0]) begin n_fail++; $display("FAIL b2b_tail[%0d] actual v=%b cmd=%h required v=1 cmd=%h", i, out_valid, {out_opcode, out_op1, out_op2}, sb[0]); end
      void'(sb.pop_front());
      tick();
    end
    out_ready = 1'b0;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_end actual=%0d required=0", count); end
  endtask

  task automatic test_full_push_pop();
    cmd_t c;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c = '{opc: 2'(3 - i), a: 16'h1000 * 16'(i + 1), b: 16'h0001 + 16'(i)};
      drive(1'b1, c); sb.push_back(c);
      tick();
    end
    n_tests++; if ({count, overflow} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL full_setup actual cnt=%0d ovf=%b required cnt=4 ovf=0", count, overflow); end
    c = '{opc: 2'd2, a: 16'h7777, b: 16'h8888};
    drive(1'b1, c); out_ready = 1'b1;
    n_tests++; if ({out_opcode, out_op1, out_op2} !== sb[0]) begin n_fail++; $display("FAIL full_pop_head actual=%h required=%h", {out_opcode, out_op1, out_op2}, sb[0]); end
    void'(sb.pop_front());
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if ({count, overflow, in_ready} !== {3'd3, 1'b1, 1'b1}) begin n_fail++; $display("FAIL full_push_pop actual cnt=%0d ovf=%b rdy=%b required cnt=3 ovf=1 rdy=1", count, overflow, in_ready); end
    n_tests++; if ({out_opcode, out_op1, out_op2} !== sb[0]) begin n_fail++; $display("FAIL full_next_head actual=%h required=%h", {out_opcode, out_op1, out_op2}, sb[0]); end
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL rmid_setup actual=%0d required=3", count); end
    c = '{opc: 2'd1, a: 16'hAAAA, b: 16'h5555};
    rst = 1'b1; drive(1'b1, c);
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready actual=%b required=0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    n_tests++;
    if ({out_valid, count, overflow, out_opcode, out_op1, out_op2} !== 39'd0) begin
      n_fail++; $display("FAIL rmid_state actual v=%b cnt=%0d ovf=%b out=%h required all zero",
                         out_valid, count, overflow, {out_opcode, out_op1, out_op2});
    end
    c = '{opc: 2'd3, a: 16'h1234, b: 16'h00FF};
    drive(1'b1, c); sb.push_back(c);
    tick();
    in_valid = 1'b0;
    n_tests++; if ({count, out_opcode, out_op1, out_op2} !== {3'd1, sb[0]}) begin n_fail++; $display("FAIL rmid_push actual cnt=%0d cmd=%h required cnt=1 cmd=%h", count, {out_opcode, out_op1, out_op2}, sb[0]); end
    n_tests++; if (alu(out_opcode, out_op1, out_op2) !== 16'h12FF) begin n_fail++; $display("FAIL rmid_alu actual=%h required=12FF", alu(out_opcode, out_op1, out_op2)); end
    out_ready = 1'b1;
    void'(sb.pop_front());
    tick();
    out_ready = 1'b0;
    n_tests++; if ({out_valid, count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL rmid_alone actual v=%b cnt=%0d required v=0 cnt=0", out_valid, count); end
  endtask

  task automatic test_empty_pop();
    cmd_t c;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if ({out_valid, count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL empty_pop[%0d] actual v=%b cnt=%0d required v=0 cnt=0", i, out_valid, count); end
    end
    out_ready = 1'b0;
    c = '{opc: 2'd2, a: 16'h00FF, b: 16'h0F0F};
    drive(1'b1, c); sb.push_back(c);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_no_bypass actual=%b required=0", out_valid); end
    tick();
    in_valid = 1'b0;
    n_tests++; if ({out_valid, count, out_opcode, out_op1, out_op2} !== {1'b1, 3'd1, sb[0]}) begin n_fail++; $display("FAIL empty_latency actual v=%b cnt=%0d cmd=%h required v=1 cnt=1 cmd=%h", out_valid, count, {out_opcode, out_op1, out_op2}, sb[0]); end
    n_tests++; if (alu(out_opcode, out_op1, out_op2) !== 16'h000F) begin n_fail++; $display("FAIL empty_alu actual=%h required=000F", alu(out_opcode, out_op1, out_op2)); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op1 = '0; in_op2 = '0; in_opcode = '0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_full_push_pop();
    test_reset_mid();
    test_empty_pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
